compound_assign_engine: RTL and testbench

- Sequential execution engine for SystemVerilog assignment-expression semantics: `=`, compound assignments, and pre/post increment/decrement.
- Applies each operation to a small signed register file.
- Returns the expression value (what `y = x++` or `y = (z >>= 1)` would yield) and the updated register value over a valid/ready response channel.
- Serves as the clocked, handshaked counterpart to the combinational assignment-expression tests in the frontend suite; used as a synthesis and formal regression design.

---
 rtl/compound_assign_engine.sv | 253 +++++++++++++++++++++++++
 tb/tb_compound_assign_engine.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/compound_assign_engine.sv
// compound_assign_engine: clocked assignment-expression engine applying `=`, compound
// assignments and pre/post inc/dec to a small register file, with valid/ready channels.
module compound_assign_engine #(
  parameter  int WIDTH = 32,
  parameter  int NREGS = 4,
  localparam int SELW  = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [SELW-1:0]  cmd_sel,
  input  logic [WIDTH-1:0] cmd_operand,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [SELW-1:0]  rsp_sel,
  output logic [WIDTH-1:0] rsp_val,
  output logic [WIDTH-1:0] rsp_new,
  output logic             rsp_err,
  output logic [15:0]      ops_done
);

  localparam logic [3:0] OP_MOV     = 4'd0;
  localparam logic [3:0] OP_ADD     = 4'd1;
  localparam logic [3:0] OP_SUB     = 4'd2;
  localparam logic [3:0] OP_MUL     = 4'd3;
  localparam logic [3:0] OP_SHL     = 4'd4;
  localparam logic [3:0] OP_SHR     = 4'd5;
  localparam logic [3:0] OP_ASR     = 4'd6;
  localparam logic [3:0] OP_AND     = 4'd7;
  localparam logic [3:0] OP_OR      = 4'd8;
  localparam logic [3:0] OP_XOR     = 4'd9;
  localparam logic [3:0] OP_PREINC  = 4'd10;
  localparam logic [3:0] OP_POSTINC = 4'd11;
  localparam logic [3:0] OP_PREDEC  = 4'd12;
  localparam logic [3:0] OP_POSTDEC = 4'd13;
  localparam logic [3:0] OP_READ    = 4'd14;
  localparam logic [3:0] OP_ILL     = 4'd15;

  localparam logic [WIDTH-1:0] ONE_V   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;

  logic             r_cmd_ready;
  logic             r_rsp_valid;
  logic [3:0]       r_op;
  logic [SELW-1:0]  r_sel;
  logic [WIDTH-1:0] r_operand;
  logic [WIDTH-1:0] r_regs [NREGS];

  logic [SELW-1:0]  r_rsp_sel;
  logic [WIDTH-1:0] r_rsp_val;
  logic [WIDTH-1:0] r_rsp_new;
  logic             r_rsp_err;
  logic [15:0]      r_ops_done;

  logic             w_accept;
  logic             w_fire;
  logic             w_exec;

  logic [WIDTH-1:0] w_old;
  logic [WIDTH-1:0] w_new;
  logic [WIDTH-1:0] w_val;
  logic             w_we;
  logic             w_err;
  logic             w_shbig;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next_state = S_EXEC;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_EXEC: w_next_state = S_RESP;
      S_RESP: begin
        if (w_fire) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_RESP;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_accept = 1'b0;
    w_fire   = 1'b0;
    w_exec   = 1'b0;
    case (r_state)
      S_IDLE:  w_accept = cmd_valid && r_cmd_ready;
      S_EXEC:  w_exec   = 1'b1;
      S_RESP:  w_fire   = r_rsp_valid && rsp_ready;
      default: w_exec   = 1'b0;
    endcase
  end

  // Handshake flags are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_cmd_ready <= (w_next_state == S_IDLE);
      r_rsp_valid <= (w_next_state == S_RESP);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op      <= 4'd0;
      r_sel     <= '0;
      r_operand <= '0;
    end else if (w_accept) begin
      r_op      <= cmd_op;
      r_sel     <= cmd_sel;
      r_operand <= cmd_operand;
    end else begin
      r_op      <= r_op;
      r_sel     <= r_sel;
      r_operand <= r_operand;
    end
  end

  // Shift amount is the operand taken as unsigned; oversize amounts are clamped explicitly.
  always_comb begin
    w_old   = r_regs[r_sel];
    w_shbig = (r_operand >= WIDTH_V);
    w_new   = w_old;
    w_we    = 1'b1;
    w_err   = 1'b0;
    case (r_op)
      OP_MOV:     w_new = r_operand;
      OP_ADD:     w_new = w_old + r_operand;
      OP_SUB:     w_new = w_old - r_operand;
      OP_MUL:     w_new = w_old * r_operand;
      OP_SHL: begin
        if (w_shbig) begin
          w_new = '0;
        end else begin
          w_new = w_old << r_operand;
        end
      end
      OP_SHR: begin
        if (w_shbig) begin
          w_new = '0;
        end else begin
          w_new = w_old >> r_operand;
        end
      end
      OP_ASR: begin
        if (w_shbig) begin
          w_new = {WIDTH{w_old[WIDTH-1]}};
        end else begin
          w_new = $unsigned($signed(w_old) >>> r_operand);
        end
      end
      OP_AND:     w_new = w_old & r_operand;
      OP_OR:      w_new = w_old | r_operand;
      OP_XOR:     w_new = w_old ^ r_operand;
      OP_PREINC:  w_new = w_old + ONE_V;
      OP_POSTINC: w_new = w_old + ONE_V;
      OP_PREDEC:  w_new = w_old - ONE_V;
      OP_POSTDEC: w_new = w_old - ONE_V;
      OP_READ:    w_we  = 1'b0;
      OP_ILL: begin
        w_we  = 1'b0;
        w_err = 1'b1;
      end
      default: begin
        w_we  = 1'b0;
        w_err = 1'b1;
      end
    endcase
    if ((r_op == OP_POSTINC) || (r_op == OP_POSTDEC)) begin
      w_val = w_old;
    end else begin
      w_val = w_new;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_exec && w_we) begin
      r_regs[r_sel] <= w_new;
    end else begin
      r_regs <= r_regs;
    end
  end

  // Response fields load once per command and hold until the next EXEC.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rsp_sel <= '0;
      r_rsp_val <= '0;
      r_rsp_new <= '0;
      r_rsp_err <= 1'b0;
    end else if (w_exec) begin
      r_rsp_sel <= r_sel;
      r_rsp_val <= w_val;
      r_rsp_new <= w_new;
      r_rsp_err <= w_err;
    end else begin
      r_rsp_sel <= r_rsp_sel;
      r_rsp_val <= r_rsp_val;
      r_rsp_new <= r_rsp_new;
      r_rsp_err <= r_rsp_err;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ops_done <= 16'd0;
    end else if (w_fire) begin
      r_ops_done <= r_ops_done + 16'd1;
    end else begin
      r_ops_done <= r_ops_done;
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_sel   = r_rsp_sel;
  assign rsp_val   = r_rsp_val;
  assign rsp_new   = r_rsp_new;
  assign rsp_err   = r_rsp_err;
  assign ops_done  = r_ops_done;

endmodule

// File: tb/tb_compound_assign_engine.sv
// Directed bench for compound_assign_engine: reset, inc/dec, arithmetic, shifts and
// wrap, back-pressure, illegal opcode and reset during EXEC.
module tb_compound_assign_engine;

  localparam int WIDTH = 32;
  localparam int NREGS = 4;
  localparam int SELW  = 2;

  logic             clk;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_op;
  logic [SELW-1:0]  cmd_sel;
  logic [WIDTH-1:0] cmd_operand;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [SELW-1:0]  rsp_sel;
  logic [WIDTH-1:0] rsp_val;
  logic [WIDTH-1:0] rsp_new;
  logic             rsp_err;
  logic [15:0]      ops_done;

  int          total;
  int          bad;
  logic [15:0] exp_ops;

  typedef struct {
    logic [3:0]  op;
    logic [1:0]  sel;
    logic [31:0] x;
    logic [31:0] val;
    logic [31:0] nw;
  } vec_t;

  compound_assign_engine #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_sel    (cmd_sel),
    .cmd_operand(cmd_operand),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_sel    (rsp_sel),
    .rsp_val    (rsp_val),
    .rsp_new    (rsp_new),
    .rsp_err    (rsp_err),
    .ops_done   (ops_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one command from a negedge; lat = negedges from handshake cycle to rsp_valid, -1 on timeout.
  task automatic do_cmd(input logic [3:0] op, input logic [1:0] sel, input logic [31:0] x,
                        output int lat, output logic [1:0] o_sel, output logic [31:0] o_val,
                        output logic [31:0] o_new, output logic o_err);
    int n;
    cmd_op = op; cmd_sel = sel; cmd_operand = x; cmd_valid = 1'b1;
    lat = -1; o_sel = 2'd0; o_val = 32'd0; o_new = 32'd0; o_err = 1'b0;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (cmd_ready === 1'b1) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      lat = 1;
      while (rsp_valid !== 1'b1 && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      if (rsp_valid === 1'b1) begin
        o_sel = rsp_sel; o_val = rsp_val; o_new = rsp_new; o_err = rsp_err;
        exp_ops = exp_ops + 16'd1;
      end else begin
        lat = -1;
      end
      @(negedge clk);
    end else begin
      cmd_valid = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_op = 4'd0; cmd_sel = 2'd0; cmd_operand = 32'd5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0 || ops_done !== 16'd0) begin
        bad++;
        $display("FAIL reset_hold[%0d] got ready=%b valid=%b ops=%0d want 0/0/0", i, cmd_ready, rsp_valid, ops_done);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_first_ready got %b want 1", cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    total++;
    if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_first_accept got ready=%b valid=%b want 0/0", cmd_ready, rsp_valid);
    end
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b1 || rsp_new !== 32'd5 || rsp_val !== 32'd5 || rsp_sel !== 2'd0) begin
      bad++;
      $display("FAIL reset_first_rsp got valid=%b val=%h new=%h want 1/5/5", rsp_valid, rsp_val, rsp_new);
    end
    @(negedge clk);
    exp_ops = 16'd1;
    total++;
    if (ops_done !== exp_ops) begin
      bad++;
      $display("FAIL reset_ops got %0d want %0d", ops_done, exp_ops);
    end
  endtask

  task automatic test_incdec;
    vec_t v[$];
    int lat; logic [1:0] s; logic [31:0] val, nw; logic err;
    v.push_back('{4'd0,  2'd0, 32'd0, 32'd0, 32'd0});
    v.push_back('{4'd11, 2'd0, 32'd0, 32'd0, 32'd1});
    v.push_back('{4'd13, 2'd0, 32'd0, 32'd1, 32'd0});
    v.push_back('{4'd10, 2'd0, 32'd0, 32'd1, 32'd1});
    v.push_back('{4'd12, 2'd0, 32'd0, 32'd0, 32'd0});
    v.push_back('{4'd13, 2'd0, 32'd0, 32'd0, 32'hFFFF_FFFF});
    v.push_back('{4'd11, 2'd0, 32'd0, 32'hFFFF_FFFF, 32'd0});
    foreach (v[i]) begin
      do_cmd(v[i].op, v[i].sel, v[i].x, lat, s, val, nw, err);
      total++;
      if (lat !== 2 || val !== v[i].val || nw !== v[i].nw || s !== v[i].sel || err !== 1'b0) begin
        bad++;
        $display("FAIL incdec[%0d] got lat=%0d val=%h new=%h sel=%0d err=%b want 2/%h/%h/%0d/0",
                 i, lat, val, nw, s, err, v[i].val, v[i].nw, v[i].sel);
      end
    end
    total++;
    if (ops_done !== exp_ops) begin
      bad++;
      $display("FAIL incdec_ops got %0d want %0d", ops_done, exp_ops);
    end
  endtask

  task automatic test_arith;
    vec_t v[$];
    int lat; logic [1:0] s; logic [31:0] val, nw; logic err;
    v.push_back('{4'd0,  2'd2, 32'd99,          32'd99,          32'd99});
    v.push_back('{4'd1,  2'd2, 32'd1,           32'd100,         32'd100});
    v.push_back('{4'd3,  2'd2, 32'd2,           32'd200,         32'd200});
    v.push_back('{4'd2,  2'd2, 32'd250,         32'hFFFF_FFCE,   32'hFFFF_FFCE});
    v.push_back('{4'd0,  2'd1, 32'd96,          32'd96,          32'd96});
    v.push_back('{4'd5,  2'd1, 32'd2,           32'd24,          32'd24});
    v.push_back('{4'd5,  2'd1, 32'hFFFF_FFFF,   32'd0,           32'd0});
    v.push_back('{4'd0,  2'd2, 32'hFFFF_FFFD,   32'hFFFF_FFFD,   32'hFFFF_FFFD});
    v.push_back('{4'd3,  2'd2, 32'd7,           32'hFFFF_FFEB,   32'hFFFF_FFEB});
    v.push_back('{4'd0,  2'd2, 32'h0000_F0F0,   32'h0000_F0F0,   32'h0000_F0F0});
    v.push_back('{4'd7,  2'd2, 32'h0000_FF00,   32'h0000_F000,   32'h0000_F000});
    v.push_back('{4'd8,  2'd2, 32'h0000_000F,   32'h0000_F00F,   32'h0000_F00F});
    v.push_back('{4'd9,  2'd2, 32'h0000_FFFF,   32'h0000_0FF0,   32'h0000_0FF0});
    v.push_back('{4'd4,  2'd2, 32'd4,           32'h0000_FF00,   32'h0000_FF00});
    v.push_back('{4'd14, 2'd2, 32'd123,         32'h0000_FF00,   32'h0000_FF00});
    v.push_back('{4'd4,  2'd2, 32'd32,          32'd0,           32'd0});
    foreach (v[i]) begin
      do_cmd(v[i].op, v[i].sel, v[i].x, lat, s, val, nw, err);
      total++;
      if (lat !== 2 || val !== v[i].val || nw !== v[i].nw || s !== v[i].sel || err !== 1'b0) begin
        bad++;
        $display("FAIL arith[%0d] got lat=%0d val=%h new=%h sel=%0d err=%b want 2/%h/%h/%0d/0",
                 i, lat, val, nw, s, err, v[i].val, v[i].nw, v[i].sel);
      end
    end
  endtask

  task automatic test_shift_wrap;
    vec_t v[$];
    int lat; logic [1:0] s; logic [31:0] val, nw; logic err;
    v.push_back('{4'd0,  2'd3, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000});
    v.push_back('{4'd6,  2'd3, 32'd4,         32'hF800_0000, 32'hF800_0000});
    v.push_back('{4'd0,  2'd3, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000});
    v.push_back('{4'd5,  2'd3, 32'd4,         32'h0800_0000, 32'h0800_0000});
    v.push_back('{4'd0,  2'd3, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000});
    v.push_back('{4'd6,  2'd3, 32'd32,        32'hFFFF_FFFF, 32'hFFFF_FFFF});
    v.push_back('{4'd0,  2'd3, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000});
    v.push_back('{4'd6,  2'd3, 32'hFFFF_FFFF, 32'd0,         32'd0});
    v.push_back('{4'd0,  2'd3, 32'h8000_0001, 32'h8000_0001, 32'h8000_0001});
    v.push_back('{4'd5,  2'd3, 32'd31,        32'd1,         32'd1});
    v.push_back('{4'd4,  2'd3, 32'd31,        32'h8000_0000, 32'h8000_0000});
    v.push_back('{4'd0,  2'd3, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF});
    v.push_back('{4'd1,  2'd3, 32'd1,         32'h8000_0000, 32'h8000_0000});
    v.push_back('{4'd12, 2'd3, 32'd0,         32'h7FFF_FFFF, 32'h7FFF_FFFF});
    v.push_back('{4'd11, 2'd3, 32'd0,         32'h7FFF_FFFF, 32'h8000_0000});
    foreach (v[i]) begin
      do_cmd(v[i].op, v[i].sel, v[i].x, lat, s, val, nw, err);
      total++;
      if (lat !== 2 || val !== v[i].val || nw !== v[i].nw || s !== v[i].sel || err !== 1'b0) begin
        bad++;
        $display("FAIL shift[%0d] got lat=%0d val=%h new=%h sel=%0d err=%b want 2/%h/%h/%0d/0",
                 i, lat, val, nw, s, err, v[i].val, v[i].nw, v[i].sel);
      end
    end
  endtask

  task automatic test_back_to_back_stall;
    int n;
    rsp_ready = 1'b0;
    cmd_op = 4'd0; cmd_sel = 2'd1; cmd_operand = 32'd7; cmd_valid = 1'b1;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n !== 2) begin
      bad++;
      $display("FAIL stall_latency got %0d want 2", n);
    end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || rsp_val !== 32'd7 || rsp_new !== 32'd7 ||
          rsp_sel !== 2'd1 || ops_done !== exp_ops) begin
        bad++;
        $display("FAIL stall_hold[%0d] got valid=%b ready=%b val=%h sel=%0d ops=%0d want 1/0/7/1/%0d",
                 i, rsp_valid, cmd_ready, rsp_val, rsp_sel, ops_done, exp_ops);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    cmd_valid = 1'b0;
    @(negedge clk);
    exp_ops = exp_ops + 16'd1;
    total++;
    if (ops_done !== exp_ops || cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_val !== 32'd7) begin
      bad++;
      $display("FAIL stall_release got ops=%0d ready=%b valid=%b val=%h want %0d/1/0/7",
               ops_done, cmd_ready, rsp_valid, rsp_val, exp_ops);
    end
  endtask

  task automatic test_illegal_reset;
    int lat; logic [1:0] s; logic [31:0] val, nw; logic err;
    do_cmd(4'd0, 2'd1, 32'd7, lat, s, val, nw, err);
    do_cmd(4'd15, 2'd1, 32'd99, lat, s, val, nw, err);
    total++;
    if (lat !== 2 || err !== 1'b1 || val !== 32'd7 || nw !== 32'd7) begin
      bad++;
      $display("FAIL illegal got lat=%0d err=%b val=%h new=%h want 2/1/7/7", lat, err, val, nw);
    end
    do_cmd(4'd14, 2'd1, 32'd0, lat, s, val, nw, err);
    total++;
    if (lat !== 2 || err !== 1'b0 || val !== 32'd7 || nw !== 32'd7) begin
      bad++;
      $display("FAIL illegal_nowrite got lat=%0d err=%b val=%h new=%h want 2/0/7/7", lat, err, val, nw);
    end
    cmd_op = 4'd0; cmd_sel = 2'd2; cmd_operand = 32'd55; cmd_valid = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b0 || ops_done !== 16'd0 || rsp_val !== 32'd0) begin
      bad++;
      $display("FAIL midreset got valid=%b ready=%b ops=%0d val=%h want 0/0/0/0",
               rsp_valid, cmd_ready, ops_done, rsp_val);
    end
    rst_n = 1'b1;
    exp_ops = 16'd0;
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL midreset_release got valid=%b ready=%b want 0/1", rsp_valid, cmd_ready);
    end
    for (int r = 0; r < NREGS; r++) begin
      do_cmd(4'd14, 2'(r), 32'd0, lat, s, val, nw, err);
      total++;
      if (lat !== 2 || val !== 32'd0 || nw !== 32'd0 || err !== 1'b0) begin
        bad++;
        $display("FAIL midreset_reg[%0d] got lat=%0d val=%h new=%h want 2/0/0", r, lat, val, nw);
      end
    end
    total++;
    if (ops_done !== exp_ops) begin
      bad++;
      $display("FAIL midreset_ops got %0d want %0d", ops_done, exp_ops);
    end
  endtask

  initial begin
    total = 0; bad = 0; exp_ops = 16'd0;
    rst_n = 1'b0; rsp_ready = 1'b1; cmd_valid = 1'b0;
    cmd_op = 4'd0; cmd_sel = 2'd0; cmd_operand = 32'd0;
    test_reset();
    test_incdec();
    test_arith();
    test_shift_wrap();
    test_back_to_back_stall();
    test_illegal_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
